btn_input_conditioner: RTL and testbench

- Sits upstream of the boot-select sequencer in the badge bootloader top.
- Synchronises the raw active-low badge buttons and the USB VBUS-detect pin to the system clock and debounces each input.
- Produces clean pressed levels, one-cycle press/release events and long-press flags.
- Raises a `valid` flag once the initial sampling window has elapsed, so the sequencer never decides a boot mode from unsettled inputs.

---
 rtl/btn_input_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_btn_input_conditioner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_input_conditioner.sv
// -----------------------------------------------------------------------------
// btn_input_conditioner
//
// Input conditioning for the boot-select sequencer. It synchronises the raw
// active-low buttons and the VBUS-detect pin, debounces every channel, derives
// one-cycle press/release events and long-press levels, and raises `valid`
// once the startup sampling window has elapsed.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   btn          in   [N_BTN] raw buttons, active-low, asynchronous
//   usb_vdet     in   raw VBUS detect, active-high, asynchronous
//   btn_stable   out  [N_BTN] debounced level, 1 = pressed
//   btn_press    out  [N_BTN] one-cycle pulse on a stable 0->1 transition
//   btn_release  out  [N_BTN] one-cycle pulse on a stable 1->0 transition
//   btn_long     out  [N_BTN] level, set after LONGPRESS_CYCLES of stable hold
//   vdet_stable  out  debounced usb_vdet
//   valid        out  high once the startup window has completed
// -----------------------------------------------------------------------------
module btn_input_conditioner #(
  parameter int N_BTN            = 8,
  parameter int DEBOUNCE_CYCLES  = 16000,
  parameter int LONGPRESS_CYCLES = 8000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic             usb_vdet,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             vdet_stable,
  output logic             valid
);

  // Channel N_BTN is VBUS detect; channels 0..N_BTN-1 are the buttons.
  localparam int N_CH = N_BTN + 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int LP_W = $clog2(LONGPRESS_CYCLES);
  localparam int SU_W = $clog2(DEBOUNCE_CYCLES + 3);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONGPRESS_CYCLES - 1);
  // Long enough for an input held through reset to clear the synchroniser
  // and a full debounce window before the sequencer looks at it.
  localparam logic [SU_W-1:0] SU_LAST = SU_W'(DEBOUNCE_CYCLES + 2);

  // Synchronisers
  logic [N_BTN-1:0] btn_meta_q, btn_sync_q;
  logic             vdet_meta_q, vdet_sync_q;

  // Debounce
  logic [N_CH-1:0]  ch_in;
  logic [DB_W-1:0]  db_cnt_q [N_CH];
  logic [DB_W-1:0]  db_cnt_d [N_CH];
  logic [N_CH-1:0]  stable_q, stable_d;

  // Events and long press
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic [LP_W-1:0]  hold_cnt_q [N_BTN];
  logic [LP_W-1:0]  hold_cnt_d [N_BTN];

  // Startup window
  logic [SU_W-1:0]  su_cnt_q, su_cnt_d;
  logic             valid_q, valid_d;

  // Synchroniser flops reset to "released / no VBUS" so nothing looks
  // pressed until real samples have propagated through.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (reset) begin
      btn_meta_q  <= '1;
      btn_sync_q  <= '1;
      vdet_meta_q <= 1'b0;
      vdet_sync_q <= 1'b0;
    end else begin
      btn_meta_q  <= btn;
      btn_sync_q  <= btn_meta_q;
      vdet_meta_q <= usb_vdet;
      vdet_sync_q <= vdet_meta_q;
    end
  end

  // Buttons are inverted here so everything downstream is active-high.
  assign ch_in = {vdet_sync_q, ~btn_sync_q};

  // Debounce: the stable value flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; a single agreeing sample restarts the window.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < N_CH; i++) begin
      db_cnt_d[i] = '0;
      if (ch_in[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ch_in[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Events are registered off the same edge that updates the stable level,
  // so a pulse coincides with the first cycle the new level is visible.
  always_comb begin
    press_d   = '0;
    release_d = '0;
    if (valid_q) begin
      press_d   = stable_d[N_BTN-1:0] & ~stable_q[N_BTN-1:0];
      release_d = ~stable_d[N_BTN-1:0] & stable_q[N_BTN-1:0];
    end
  end

  // Long press: the hold counter only advances once the button is already
  // stably pressed, and is cleared on the very edge the stable level falls so
  // btn_long drops together with btn_stable.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      hold_cnt_d[i] = hold_cnt_q[i];
      long_d[i]     = long_q[i];
      if (!stable_d[i]) begin
        hold_cnt_d[i] = '0;
        long_d[i]     = 1'b0;
      end else if (stable_q[i]) begin
        if (hold_cnt_q[i] == LP_LAST) begin
          long_d[i] = 1'b1;
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + LP_W'(1);
        end
      end
    end
  end

  // Startup: count edges since reset, latch valid, then freeze the counter.
  always_comb begin
    su_cnt_d = su_cnt_q;
    valid_d  = valid_q;
    if (!valid_q) begin
      if (su_cnt_q == SU_LAST) begin
        valid_d = 1'b1;
      end else begin
        su_cnt_d = su_cnt_q + SU_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-channel counter arrays are reset explicitly; they are
      // tiny flop arrays, not RAM, and the startup window relies on them
      // starting from zero.
      db_cnt_q   <= '{default: '0};
      hold_cnt_q <= '{default: '0};
      stable_q   <= '0;
      press_q    <= '0;
      release_q  <= '0;
      long_q     <= '0;
      su_cnt_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      stable_q   <= stable_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      su_cnt_q   <= su_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign btn_stable  = stable_q[N_BTN-1:0];
  assign vdet_stable = stable_q[N_BTN];
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_btn_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_input_conditioner
//
// Self-checking bench for btn_input_conditioner with DEBOUNCE_CYCLES=4 and
// LONGPRESS_CYCLES=16. A behavioural model tracks expected outputs: an input
// becomes stable once the last DEBOUNCE_CYCLES synchronised samples all agree,
// events fire on stable changes once the startup window is over, and a long
// press is declared LONGPRESS_CYCLES edges after the stable rise.
// -----------------------------------------------------------------------------
module tb_btn_input_conditioner;

  localparam int N_BTN = 8;
  localparam int DEB   = 4;
  localparam int LP    = 16;
  localparam int N_CH  = N_BTN + 1;
  localparam int OW    = 4 * N_BTN + 2;
  // Leading "released" samples standing in for the reset state of the
  // synchroniser, enough to fill the first debounce window.
  localparam int PAD   = DEB + 2;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic [N_BTN-1:0] btn      = '1;
  logic             usb_vdet = 1'b0;
  logic [N_BTN-1:0] btn_stable, btn_press, btn_release, btn_long;
  logic             vdet_stable, valid;

  int n_cmp  = 0;
  int n_fail = 0;

  btn_input_conditioner #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (DEB),
    .LONGPRESS_CYCLES(LP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .usb_vdet   (usb_vdet),
    .btn_stable (btn_stable),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .vdet_stable(vdet_stable),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0]  hist[$];          // active-high samples, one per edge
  logic [N_CH-1:0]  m_stable  = '0;
  logic [N_BTN-1:0] m_press   = '0;
  logic [N_BTN-1:0] m_release = '0;
  int               m_rise [N_BTN];
  int               m_edge    = 0;    // edges since reset was released

  task automatic model_edge();
    logic [N_CH-1:0] nxt;
    logic            all1, all0;
    if (reset) begin
      hist.delete();
      for (int j = 0; j < PAD; j++) hist.push_back('0);
      m_stable  = '0;
      m_press   = '0;
      m_release = '0;
      m_edge    = 0;
      for (int i = 0; i < N_BTN; i++) m_rise[i] = 0;
      return;
    end
    m_edge++;
    hist.push_back({usb_vdet, ~btn});
    // The samples seen by the debouncer at this edge are the raw values from
    // edges m_edge-1-DEB .. m_edge-2, stored at hist[m_edge .. m_edge+DEB-1].
    nxt = m_stable;
    for (int c = 0; c < N_CH; c++) begin
      all1 = 1'b1;
      all0 = 1'b1;
      for (int j = m_edge; j < m_edge + DEB; j++) begin
        if (hist[j][c]) all0 = 1'b0;
        else            all1 = 1'b0;
      end
      if (all1)      nxt[c] = 1'b1;
      else if (all0) nxt[c] = 1'b0;
    end
    m_press   = '0;
    m_release = '0;
    if (m_edge >= DEB + 4) begin
      m_press   = nxt[N_BTN-1:0] & ~m_stable[N_BTN-1:0];
      m_release = ~nxt[N_BTN-1:0] & m_stable[N_BTN-1:0];
    end
    for (int i = 0; i < N_BTN; i++)
      if (nxt[i] && !m_stable[i]) m_rise[i] = m_edge;
    m_stable = nxt;
  endtask

  function automatic logic [OW-1:0] exp_v();
    logic [N_BTN-1:0] lng;
    for (int i = 0; i < N_BTN; i++)
      lng[i] = m_stable[i] && (m_edge - m_rise[i] >= LP);
    return {m_stable[N_BTN-1:0], m_press, m_release, lng, m_stable[N_BTN],
            (m_edge >= DEB + 3)};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {btn_stable, btn_press, btn_release, btn_long, vdet_stable, valid};
  endfunction

  // One clock edge: model samples the inputs the DUT sees, outputs are then
  // read on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    reset = 1'b1; btn = '1; usb_vdet = 1'b0;
    step(); step();
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", obs());
    end
    reset = 1'b0;
    n = 0;
    while (!valid && n < 20) begin
      step(); n++;
      n_cmp++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL reset_model: got %h want %h", obs(), exp_v());
      end
    end
    n_cmp++;
    if (n != DEB + 3) begin
      n_fail++; $display("FAIL valid_latency: got %0d edges want %0d", n, DEB + 3);
    end
  endtask

  task automatic test_reset_held();
    int   n, presses;
    logic pre_ok;
    reset = 1'b1; btn = '1; btn[0] = 1'b0; usb_vdet = 1'b1;
    step(); step();
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL held_reset_state: got %h want 0", obs());
    end
    reset = 1'b0;
    n = 0; presses = 0; pre_ok = 1'b0;
    while (!valid && n < 20) begin
      pre_ok = btn_stable[0] && vdet_stable;
      step(); n++;
      presses += int'(btn_press[0]);
      n_cmp++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL held_model: got %h want %h", obs(), exp_v());
      end
    end
    n_cmp++;
    if (pre_ok !== 1'b1) begin
      n_fail++; $display("FAIL held_before_valid: got %b want 1", pre_ok);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      presses += int'(btn_press[0]);
    end
    n_cmp++;
    if (presses != 0) begin
      n_fail++; $display("FAIL held_no_press: got %0d pulses want 0", presses);
    end
    btn[0] = 1'b1; usb_vdet = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL held_release_model: got %h want %h", obs(), exp_v());
      end
    end
  endtask

  task automatic test_press_long();
    int   n;
    logic prev_long;
    btn[2] = 1'b0;
    n = 0;
    while (!btn_stable[2] && n < 20) begin
      step(); n++;
      n_cmp++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL press_model: got %h want %h", obs(), exp_v());
      end
    end
    n_cmp++;
    if (n != DEB + 2) begin
      n_fail++; $display("FAIL press_latency: got %0d edges want %0d", n, DEB + 2);
    end
    n_cmp++;
    if (btn_press !== 8'h04) begin
      n_fail++; $display("FAIL press_pulse: got %h want 04", btn_press);
    end
    step();
    n_cmp++;
    if (btn_press !== 8'h00) begin
      n_fail++; $display("FAIL press_one_cycle: got %h want 00", btn_press);
    end
    n = 1;
    while (!btn_long[2] && n < 40) begin
      step(); n++;
      n_cmp++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL long_model: got %h want %h", obs(), exp_v());
      end
    end
    n_cmp++;
    if (n != LP) begin
      n_fail++; $display("FAIL long_latency: got %0d edges want %0d", n, LP);
    end
    btn[2] = 1'b1;
    n = 0; prev_long = 1'b0;
    while (btn_stable[2] && n < 20) begin
      prev_long = btn_long[2];
      step(); n++;
    end
    n_cmp++;
    if ({prev_long, btn_long[2]} !== 2'b10) begin
      n_fail++; $display("FAIL long_clear_edge: got %b want 10", {prev_long, btn_long[2]});
    end
    n_cmp++;
    if (btn_release !== 8'h04) begin
      n_fail++; $display("FAIL release_pulse: got %h want 04", btn_release);
    end
    step();
    n_cmp++;
    if (obs() !== exp_v()) begin
      n_fail++; $display("FAIL release_one_cycle: got %h want %h", obs(), exp_v());
    end
  endtask

  task automatic test_glitch();
    logic [2:0] seen;
    seen = '0;
    for (int r = 0; r < 10; r++) begin
      btn[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        seen |= {btn_stable[1], btn_press[1], btn_release[1]};
      end
      btn[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        step();
        seen |= {btn_stable[1], btn_press[1], btn_release[1]};
        n_cmp++;
        if (obs() !== exp_v()) begin
          n_fail++; $display("FAIL glitch_model: got %h want %h", obs(), exp_v());
        end
      end
    end
    n_cmp++;
    if (seen !== 3'b000) begin
      n_fail++; $display("FAIL glitch_reject: got %b want 000", seen);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    btn[0] = 1'b0; btn[7] = 1'b0; usb_vdet = 1'b1;
    n = 0;
    while (!btn_stable[0] && n < 20) begin
      step(); n++;
    end
    n_cmp++;
    if ({btn_stable[7], vdet_stable, btn_press} !== {2'b11, 8'h81}) begin
      n_fail++;
      $display("FAIL simultaneous: got %b%b %h want 11 81",
               btn_stable[7], vdet_stable, btn_press);
    end
    btn = '1; usb_vdet = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL simultaneous_model: got %h want %h", obs(), exp_v());
      end
    end
  endtask

  task automatic test_reset_long();
    int n, presses;
    btn[3] = 1'b0;
    n = 0;
    while (!btn_long[3] && n < 40) begin
      step(); n++;
    end
    n_cmp++;
    if (btn_long[3] !== 1'b1) begin
      n_fail++; $display("FAIL reset_long_setup: got %b want 1", btn_long[3]);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (obs() !== '0) begin
      n_fail++; $display("FAIL reset_long_clear: got %h want 0", obs());
    end
    step();
    reset = 1'b0;
    n = 0; presses = 0;
    while (!btn_stable[3] && n < 20) begin
      step(); n++;
      presses += int'(btn_press[3]);
    end
    n_cmp++;
    if (n != DEB + 2) begin
      n_fail++; $display("FAIL reset_long_stable: got %0d edges want %0d", n, DEB + 2);
    end
    n = 0;
    while (!btn_long[3] && n < 40) begin
      step(); n++;
      presses += int'(btn_press[3]);
      n_cmp++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL reset_long_model: got %h want %h", obs(), exp_v());
      end
    end
    n_cmp++;
    if (n != LP) begin
      n_fail++; $display("FAIL reset_long_latency: got %0d edges want %0d", n, LP);
    end
    n_cmp++;
    if (presses != 0) begin
      n_fail++; $display("FAIL reset_long_no_press: got %0d pulses want 0", presses);
    end
    btn[3] = 1'b1;
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_random();
    int rate;
    for (int seg = 0; seg < 15; seg++) begin
      case ($urandom_range(0, 2))
        0:       rate = 3;
        1:       rate = 10;
        default: rate = 40;
      endcase
      for (int c = 0; c < 200; c++) begin
        reset = ($urandom_range(0, 599) == 0);
        for (int i = 0; i < N_BTN; i++)
          if ($urandom_range(0, rate - 1) == 0) btn[i] = ~btn[i];
        if ($urandom_range(0, rate - 1) == 0) usb_vdet = ~usb_vdet;
        step();
        n_cmp++;
        if (obs() !== exp_v()) begin
          n_fail++; $display("FAIL random_model: got %h want %h", obs(), exp_v());
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_held();
    test_press_long();
    test_glitch();
    test_simultaneous();
    test_reset_long();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
